// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width, ALU opcodes and sequencer state encoding
package cpu_pkg;
   localparam int WIDTH = 24;
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_LESS = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned shift-add multiplier, one partial product per enabled cycle
module shift_add_mul #(
   parameter int WIDTH  = 24,
   parameter int CYCLES = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = $clog2(CYCLES + 1);
   logic [2*WIDTH-1:0] acc, mc;
   logic [WIDTH-1:0]   mp;
   logic [CW-1:0]      cnt;
   assign prod = mp[0] ? acc + mc : acc;
   assign done = en && cnt == CW'(CYCLES - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         mc  <= '0;
         mp  <= '0;
         cnt <= '0;
      end else if (start) begin
         acc <= '0;
         mc  <= {{WIDTH{1'b0}}, a};
         mp  <= b;
         cnt <= '0;
      end else if (en) begin
         acc <= prod;
         mc  <= mc << 1;
         mp  <= mp >> 1;
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: single issue point for ALU ops; drives the external ALU mux or runs MUL internally
module alu_op_sequencer #(
   parameter int WIDTH      = cpu_pkg::WIDTH,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [2:0]       Selector,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Ovf,
   output logic             Err,
   output logic             busy
);
   import cpu_pkg::*;
   state_t             state, next;
   logic [2:0]         opc;
   logic               accept, illegal, mul_done;
   logic [2*WIDTH-1:0] prod;
   assign accept  = op_valid && op_ready;
   assign illegal = op_code[2:1] == 2'b11;
   shift_add_mul #(.WIDTH(WIDTH), .CYCLES(MUL_CYCLES)) u_mul (
      .clk  (Clock),
      .rst  (Reset),
      .start(accept && op_code == OP_MUL),
      .en   (state == MUL),
      .a    (A),
      .b    (B),
      .done (mul_done),
      .prod (prod)
   );
   always_comb begin
      next      = state;
      op_ready  = state == IDLE;
      busy      = state != IDLE;
      res_valid = state == DONE;
      Selector  = state == EXEC ? opc : state == MUL ? OP_MUL : OP_AND;
      next      = (state == IDLE && op_valid) ? (op_code == OP_MUL ? MUL : illegal ? DONE : EXEC) :
                  (state == EXEC)             ? DONE :
                  (state == MUL && mul_done)  ? DONE :
                  (state == DONE && res_ready) ? IDLE : state;
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= IDLE;
         opc    <= OP_AND;
         Result <= '0;
         Ovf    <= 1'b0;
         Err    <= 1'b0;
      end else begin
         state <= next;
         if (accept) opc <= op_code;
         if (accept && illegal) begin
            Result <= '0;
            Ovf    <= 1'b0;
            Err    <= 1'b1;
         end
         if (state == EXEC) begin
            Result <= alu_result;
            Ovf    <= 1'b0;
            Err    <= 1'b0;
         end
         if (mul_done) begin
            Result <= prod[WIDTH-1:0];
            Ovf    <= |prod[2*WIDTH-1:WIDTH];
            Err    <= 1'b0;
         end
      end
   end
endmodule
